// File: rtl/emulib_fifo_stream_out_pkg.sv
// ---------------------------------------------------------------------------
// emulib_fifo_stream_out_pkg
//   Shared constants and helpers for the emulib FIFO stream adapters
//   (read-side FIFO-to-stream today, write-side stream-to-FIFO later).
//
//   BUF_DEPTH : entries in the adapter's prefetch buffer
//   PTR_W     : width of the buffer head/tail pointers
//   ptr_inc() : pointer increment with explicit wrap at BUF_DEPTH-1
// ---------------------------------------------------------------------------
package emulib_fifo_stream_out_pkg;

    localparam int BUF_DEPTH = 3;
    localparam int PTR_W     = 2;

    typedef logic [PTR_W-1:0] ptr_t;

    // BUF_DEPTH is not a power of two, so the wrap must be an explicit compare.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/emulib_fifo_stream_out.sv
// ---------------------------------------------------------------------------
// emulib_fifo_stream_out
//   Read-side adapter for the emulib FIFO. Turns the FIFO read port
//   (rinc strobe / rempty flag / rdata one cycle after a fired read) into a
//   valid/ready stream master. A 3-entry prefetch buffer covers the read
//   latency so the stream sustains one beat per cycle, and fifo_rinc is a
//   function of registers and fifo_rempty only (no path from m_ready).
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   fifo_rinc    : out  read strobe; read fires when fifo_rinc && !fifo_rempty
//   fifo_rempty  : in   FIFO empty flag (registered in the FIFO)
//   fifo_rdata   : in   read data, valid the cycle after a fired read
//   m_valid      : out  stream beat valid
//   m_ready      : in   stream consumer ready
//   m_data       : out  stream beat data
//   occupancy    : out  entries currently held in the prefetch buffer (0..3)
// ---------------------------------------------------------------------------
module emulib_fifo_stream_out
    import emulib_fifo_stream_out_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fifo_rinc,
    input  logic             fifo_rempty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] r_buf [BUF_DEPTH];
    ptr_t             r_hp;
    ptr_t             r_tp;
    logic [1:0]       r_occ;
    logic             r_pend;   // read fired last cycle; fifo_rdata lands now

    logic       w_fire;
    logic       w_push;
    logic       w_pop;
    logic [2:0] w_level;
    logic [1:0] w_occ_next;

    // Count the in-flight read as occupied so a landing beat always has room.
    assign w_level   = {1'b0, r_occ} + {2'b00, r_pend};
    assign fifo_rinc = !fifo_rempty && (w_level < 3'd3);
    assign w_fire    = fifo_rinc && !fifo_rempty;
    assign w_push    = r_pend;

    assign m_valid   = (r_occ != 2'd0);
    assign w_pop     = m_valid && m_ready;
    assign m_data    = r_buf[r_hp];
    assign occupancy = r_occ;

    always_comb begin
        w_occ_next = r_occ;
        case ({w_push, w_pop})
            2'b10:   w_occ_next = r_occ + 2'd1;
            2'b01:   w_occ_next = r_occ - 2'd1;
            default: w_occ_next = r_occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ  <= 2'd0;
            r_pend <= 1'b0;     // in-flight read is dropped; FIFO resets too
            r_hp   <= '0;
            r_tp   <= '0;
        end else begin
            r_occ  <= w_occ_next;
            r_pend <= w_fire;
            if (w_pop)  r_hp <= ptr_inc(r_hp);
            if (w_push) r_tp <= ptr_inc(r_tp);
        end
    end

    // Data storage is not reset; validity is tracked by r_occ alone.
    // Capture only in the push cycle so FIFO rdata hold behaviour is irrelevant.
    always_ff @(posedge clk) begin
        if (!rst && w_push) r_buf[r_tp] <= fifo_rdata;
    end

endmodule
